// File: rtl/multiplicacao_booth_pkg.sv
// Shared types and constants for the Booth multiplier: FSM states, default
// operand width / iteration count, and the sign-extended accumulator type.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_ITER  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [MULT_WIDTH:0] acc_t;

endpackage

// File: rtl/multiplicacao_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of the combined {A,Q,Q_1} register. Purely combinational.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic signed [WIDTH:0]   i_a,
  input  logic        [WIDTH-1:0] i_q,
  input  logic                    i_q1,
  input  logic signed [WIDTH-1:0] i_m,
  output logic signed [WIDTH:0]   o_a,
  output logic        [WIDTH-1:0] o_q,
  output logic                    o_q1
);

  logic signed [WIDTH:0] w_m_ext;
  logic signed [WIDTH:0] w_sum;

  // The extra accumulator bit keeps A - (-2^(WIDTH-1)) representable.
  assign w_m_ext = {i_m[WIDTH-1], i_m};

  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q1})
      2'b01:   w_sum = i_a + w_m_ext;
      2'b10:   w_sum = i_a - w_m_ext;
      default: w_sum = i_a;
    endcase
  end

  assign o_a  = w_sum >>> 1;
  assign o_q  = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_q1 = i_q[0];

endmodule

// File: rtl/multiplicacao_booth.sv
// Sequential signed radix-2 Booth multiplier, one iteration per falling clock edge.
// Optional macro MULT_EARLY_TERM_EN: a zero operand skips the iterations.
module multiplicacao_booth
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int ITER  = MULT_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] Multiplicando,
  input  logic [WIDTH-1:0] Multiplicador,
  input  logic             multIn,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             multOut,
  output logic             busy
);

  localparam int CNT_W = $clog2(ITER + 1);

  state_t                   r_state, w_state_n;
  logic signed [WIDTH:0]    r_a, w_a_n;
  logic        [WIDTH-1:0]  r_q, w_q_n;
  logic                     r_q1, w_q1_n;
  logic signed [WIDTH-1:0]  r_m, w_m_n;
  logic        [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic        [WIDTH-1:0]  r_hi, w_hi_n;
  logic        [WIDTH-1:0]  r_lo, w_lo_n;
  logic                     r_done, w_done_n;
  logic                     r_busy, w_busy_n;

  logic signed [WIDTH:0]    w_a_step;
  logic        [WIDTH-1:0]  w_q_step;
  logic                     w_q1_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a_step),
    .o_q  (w_q_step),
    .o_q1 (w_q1_step)
  );

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_a     <= w_a_n;
      r_q     <= w_q_n;
      r_q1    <= w_q1_n;
      r_m     <= w_m_n;
      r_cnt   <= w_cnt_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
      r_done  <= w_done_n;
      r_busy  <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_a_n     = r_a;
    w_q_n     = r_q;
    w_q1_n    = r_q1;
    w_m_n     = r_m;
    w_cnt_n   = r_cnt;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    w_done_n  = 1'b0;
    w_busy_n  = r_busy;

    case (r_state)
      IDLE: begin
        if (multIn) begin
          w_m_n    = $signed(Multiplicando);
          w_q_n    = Multiplicador;
          w_a_n    = '0;
          w_q1_n   = 1'b0;
          w_cnt_n  = CNT_W'(ITER);
          w_busy_n = 1'b1;
`ifdef MULT_EARLY_TERM_EN
          // A zero product is {A,Q} = 0, so DONE can publish it directly.
          if (Multiplicando == '0 || Multiplicador == '0) begin
            w_q_n     = '0;
            w_state_n = DONE;
          end else begin
            w_state_n = RUN;
          end
`else
          w_state_n = RUN;
`endif
        end
      end

      RUN: begin
        w_a_n   = w_a_step;
        w_q_n   = w_q_step;
        w_q1_n  = w_q1_step;
        w_cnt_n = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_n = DONE;
        end
      end

      DONE: begin
        // After ITER shifts the full product sits in {A[WIDTH-1:0], Q}.
        w_hi_n    = r_a[WIDTH-1:0];
        w_lo_n    = r_q;
        w_done_n  = 1'b1;
        w_busy_n  = 1'b0;
        w_state_n = IDLE;
      end

      default: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign multOut = r_done;
  assign busy    = r_busy;

endmodule

// File: tb/tb_multiplicacao_booth.sv
// Self-checking bench for multiplicacao_booth: vector table, random products
// against a plain-arithmetic model, ignored restart and mid-operation reset.
module tb_multiplicacao_booth;

  logic        clock = 1'b1;
  logic        reset = 1'b0;
  logic [31:0] Multiplicando = '0;
  logic [31:0] Multiplicador = '0;
  logic        multIn = 1'b0;
  logic [31:0] Hi, Lo;
  logic        multOut, busy;

  int total = 0;
  int bad   = 0;

  multiplicacao_booth dut (
    .clock         (clock),
    .reset         (reset),
    .Multiplicando (Multiplicando),
    .Multiplicador (Multiplicador),
    .multIn        (multIn),
    .Hi            (Hi),
    .Lo            (Lo),
    .multOut       (multOut),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] q);
    longint sm, sq;
    sm = longint'($signed(m));
    sq = longint'($signed(q));
    return 64'(sm * sq);
  endfunction

  function automatic int exp_lat(input logic [31:0] m, input logic [31:0] q);
`ifdef MULT_EARLY_TERM_EN
    if (m == 0 || q == 0) return 1;
`endif
    return 33;
  endfunction

  // Issue one operation and follow it to multOut; edge 0 is the accepting negedge.
  task automatic do_op(input logic [31:0] m, input logic [31:0] q,
                       output int lat, output logic ctl_ok);
    logic [31:0] prev_hi, prev_lo;
    prev_hi = Hi;
    prev_lo = Lo;
    @(posedge clock);
    Multiplicando = m;
    Multiplicador = q;
    multIn = 1'b1;
    @(negedge clock);
    #1;
    multIn = 1'b0;
    Multiplicando = $urandom;
    Multiplicador = $urandom;
    ctl_ok = (busy === 1'b1) && (multOut === 1'b0);
    lat = -1;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clock);
      #1;
      if (multOut === 1'b1) begin
        lat = e;
        if (busy !== 1'b0) ctl_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1 || Hi !== prev_hi || Lo !== prev_lo) ctl_ok = 1'b0;
    end
  endtask

  initial begin
    vec_t        vecs[7];
    int          lat;
    logic        ok;
    int          pulses;
    logic [31:0] rm, rq;

    vecs[0] = '{32'd7,        32'd6,        32'h00000000, 32'h0000002A};
    vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[3] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4] = '{32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};
    vecs[5] = '{32'd0,        32'h12345678, 32'h00000000, 32'h00000000};
    vecs[6] = '{32'h12345678, 32'd0,        32'h00000000, 32'h00000000};

    #22;
    chk("reset_hi", 64'(Hi), 64'd0);
    chk("reset_lo", 64'(Lo), 64'd0);
    chk("reset_multOut", 64'(multOut), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(posedge clock);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].m, vecs[i].q, lat, ok);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].m, vecs[i].q)));
      chk($sformatf("vec%0d_ctl", i), 64'(ok), 64'd1);
      chk($sformatf("vec%0d_product", i), {Hi, Lo}, {vecs[i].hi, vecs[i].lo});
    end
    @(negedge clock);
    #1;
    chk("multOut_one_cycle", 64'(multOut), 64'd0);

    for (int i = 0; i < 20; i++) begin
      rm = $urandom;
      rq = $urandom;
      if (i % 7 == 3) rm = '0;
      if (i % 5 == 4) rq = 32'h80000000;
      do_op(rm, rq, lat, ok);
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat(rm, rq)));
      chk($sformatf("rand%0d_ctl", i), 64'(ok), 64'd1);
      chk($sformatf("rand%0d_product", i), {Hi, Lo}, model(rm, rq));
    end

    // 9*9 with a 2*2 request at edge 10 that must be ignored.
    @(posedge clock);
    Multiplicando = 32'd9;
    Multiplicador = 32'd9;
    multIn = 1'b1;
    @(negedge clock);
    #1;
    multIn = 1'b0;
    pulses = 0;
    lat = -1;
    for (int e = 1; e <= 45; e++) begin
      if (e == 10) begin
        @(posedge clock);
        Multiplicando = 32'd2;
        Multiplicador = 32'd2;
        multIn = 1'b1;
      end
      @(negedge clock);
      #1;
      if (e == 10) multIn = 1'b0;
      if (multOut === 1'b1) begin
        pulses++;
        if (lat < 0) lat = e;
      end
    end
    chk("restart_latency", 64'(lat), 64'd33);
    chk("restart_pulses", 64'(pulses), 64'd1);
    chk("restart_product", {Hi, Lo}, 64'h51);

    // 100*100 aborted by reset between edges 14 and 15.
    @(posedge clock);
    Multiplicando = 32'd100;
    Multiplicador = 32'd100;
    multIn = 1'b1;
    @(negedge clock);
    #1;
    multIn = 1'b0;
    for (int e = 1; e <= 14; e++) @(negedge clock);
    @(posedge clock);
    reset = 1'b0;
    #1;
    chk("abort_hi", 64'(Hi), 64'd0);
    chk("abort_lo", 64'(Lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_multOut", 64'(multOut), 64'd0);
    @(posedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clock);
      #1;
      if (multOut === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("abort_no_late_activity", 64'(pulses), 64'd0);

    do_op(32'd3, 32'hFFFFFFFD, lat, ok);
    chk("recover_latency", 64'(lat), 64'd33);
    chk("recover_product", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
